vga_pattern_gen: RTL and testbench

Parametrised VGA test-pattern source combining sync timing, pixel-tick generation and a multi-mode colour generator in one block. It replaces the fixed 3-bit switch-colour test: the single-colour path is kept, and the block adds configurable colour depth, a built-in pixel-clock divider, selectable patterns, and tear-free frame-synchronous latching of controls. It sits between board switches and the VGA DAC/pins as the standalone display bring-up top.

---
 rtl/vga_pattern_gen_if.sv | 26 ++
 rtl/vga_pattern_gen.sv | 148 ++++++++++++++
 tb/tb_vga_pattern_gen.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pattern_gen_if.sv
// Signal bundle between the VGA pattern source and its consumer: pattern
// controls flow in, sync timing, counters and pixel data flow out.
interface vga_pattern_gen_if #(
    parameter int COLOR_W = 1
);
    logic [1:0]           mode;
    logic [3*COLOR_W-1:0] color;
    logic                 hsync;
    logic                 vsync;
    logic                 video_on;
    logic [3*COLOR_W-1:0] rgb;
    logic [10:0]          pixel_x;
    logic [10:0]          pixel_y;
    logic                 p_tick;
    logic                 frame_start;

    modport master (
        input  mode, color,
        output hsync, vsync, video_on, rgb, pixel_x, pixel_y, p_tick, frame_start
    );

    modport slave (
        output mode, color,
        input  hsync, vsync, video_on, rgb, pixel_x, pixel_y, p_tick, frame_start
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source: pixel-tick divider, sync counters and a four-mode
// colour generator whose controls are latched once per frame.
module vga_pattern_gen #(
    parameter int CLK_DIV     = 2,
    parameter int COLOR_W     = 1,
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit SYNC_POL    = 1'b0,
    parameter int BAR_SHIFT   = 6,
    parameter int SQ_SHIFT    = 5,
    parameter int SCROLL_STEP = 4
) (
    input  logic              clk,
    input  logic              reset,
    vga_pattern_gen_if.master vga
);
    localparam int RGB_W   = 3 * COLOR_W;
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
    localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
    localparam logic [10:0] HS_FIRST = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_LAST  = 11'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_LAST  = 11'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [10:0] STEP     = 11'(SCROLL_STEP);

    logic [DIV_W-1:0] div_cnt_q, div_d;
    logic [10:0]      x_q, x_d;
    logic [10:0]      y_q, y_d;
    logic             wrap_q, wrap_d;
    logic [1:0]       mode_r_q, mode_d;
    logic [RGB_W-1:0] color_r_q, color_d;
    logic [10:0]      offset_q, offset_d;

    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             frame_start_q;

    logic             p_tick;
    logic [2:0]       bar_sel;
    logic [RGB_W-1:0] bar_rgb;
    logic [RGB_W-1:0] pattern;

    assign p_tick = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_d    = p_tick ? '0 : div_cnt_q + 1'b1;
        x_d      = x_q;
        y_d      = y_q;
        wrap_d   = 1'b0;
        mode_d   = mode_r_q;
        color_d  = color_r_q;
        offset_d = offset_q;
        if (p_tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    // Frame boundary: controls are sampled here so a whole frame
                    // is always drawn with one consistent setting.
                    y_d      = '0;
                    wrap_d   = 1'b1;
                    mode_d   = vga.mode;
                    color_d  = vga.color;
                    offset_d = offset_q + STEP;
                end else begin
                    y_d = y_q + 11'd1;
                end
            end else begin
                x_d = x_q + 11'd1;
            end
        end
    end

    always_comb begin
        if (mode_r_q == 2'd3) begin
            bar_sel = 3'((x_q + offset_q) >> BAR_SHIFT);
        end else begin
            bar_sel = x_q[BAR_SHIFT+2 -: 3];
        end
        bar_rgb = {{COLOR_W{bar_sel[2]}}, {COLOR_W{bar_sel[1]}}, {COLOR_W{bar_sel[0]}}};

        case (mode_r_q)
            2'd0:    pattern = color_r_q;
            2'd2:    pattern = (x_q[SQ_SHIFT] ^ y_q[SQ_SHIFT]) ? ~color_r_q : color_r_q;
            default: pattern = bar_rgb;
        endcase

        video_on_d = (x_q < H_VIS) && (y_q < V_VIS);
        hsync_d    = (x_q >= HS_FIRST && x_q <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
        vsync_d    = (y_q >= VS_FIRST && y_q <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
        rgb_d      = video_on_d ? pattern : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt_q     <= '0;
            x_q           <= '0;
            y_q           <= '0;
            wrap_q        <= 1'b0;
            mode_r_q      <= '0;
            color_r_q     <= '0;
            offset_q      <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_d;
            x_q           <= x_d;
            y_q           <= y_d;
            wrap_q        <= wrap_d;
            mode_r_q      <= mode_d;
            color_r_q     <= color_d;
            offset_q      <= offset_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            rgb_q         <= rgb_d;
            // wrap_q is high while the counters sit at (0,0) with fresh controls,
            // so the pulse lines up with that pixel's registered output.
            frame_start_q <= wrap_q;
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.rgb         = rgb_q;
    assign vga.pixel_x     = x_q;
    assign vga.pixel_y     = y_q;
    assign vga.p_tick      = p_tick;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen on a shrunken timing so several
// whole frames fit in a short run; expectations come from cycle arithmetic.
module tb_vga_pattern_gen;
    localparam int CD = 2, CW = 2;
    localparam int HD = 40, HF = 4, HS = 6, HB = 6;
    localparam int VD = 20, VF = 2, VS = 3, VB = 3;
    localparam bit POL = 1'b0;
    localparam int BS = 2, SQ = 2, STEP = 300;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FP = HT * VT;
    localparam int FC = FP * CD;

    typedef logic [32:0] vec_t;
    localparam vec_t RST_VEC = {~POL, ~POL, 31'b0};

    logic clk = 1'b0;
    logic reset = 1'b0;
    int unsigned cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;
    logic [1:0]  fm [16];
    logic [5:0]  fc [16];
    // Pixel (0,0) of frames 1..8 in mode 3: bar index = ((f*300) mod 2048 >> 2) mod 8
    logic [5:0]  scroll_exp [8] = '{6'b001111, 6'b111100, 6'b000011, 6'b110000,
                                    6'b111111, 6'b001100, 6'b110011, 6'b000000};

    vga_pattern_gen_if #(.COLOR_W(CW)) bus ();

    vga_pattern_gen #(
        .CLK_DIV(CD), .COLOR_W(CW),
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(POL), .BAR_SHIFT(BS), .SQ_SHIFT(SQ), .SCROLL_STEP(STEP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vga(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [5:0] bar(int unsigned v);
        logic [2:0] b;
        b = 3'((v >> BS) % 8);
        return {{CW{b[2]}}, {CW{b[1]}}, {CW{b[0]}}};
    endfunction

    // Expected outputs in cycle c, where c=0 is the cycle right after a reset edge.
    function automatic vec_t model(int unsigned c);
        int unsigned p, x, y, f, off, px, py;
        logic hs, vs, von, fs, pt;
        logic [5:0] rgb, col;
        logic [1:0] m;
        p  = c / CD;
        px = p % HT;
        py = (p / HT) % VT;
        pt = ((c % CD) == CD - 1);
        if (c == 0) begin
            hs = ~POL; vs = ~POL; von = 1'b0; rgb = '0; fs = 1'b0;
        end else begin
            p   = (c - 1) / CD;
            x   = p % HT;
            y   = (p / HT) % VT;
            f   = p / FP;
            m   = fm[f % 16];
            col = fc[f % 16];
            off = (f * STEP) % 2048;
            hs  = (x >= HD + HF && x < HD + HF + HS) ? POL : ~POL;
            vs  = (y >= VD + VF && y < VD + VF + VS) ? POL : ~POL;
            von = (x < HD) && (y < VD);
            fs  = (f > 0) && (p % FP == 0) && ((c - 1) % CD == 0);
            case (m)
                2'd0:    rgb = col;
                2'd1:    rgb = bar(x);
                2'd2:    rgb = ((((x >> SQ) + (y >> SQ)) % 2) == 1) ? ~col : col;
                default: rgb = bar((x + off) % 2048);
            endcase
            if (!von) rgb = '0;
        end
        return {hs, vs, von, rgb, fs, pt, 11'(px), 11'(py)};
    endfunction

    function automatic vec_t observed();
        return {bus.hsync, bus.vsync, bus.video_on, bus.rgb, bus.frame_start,
                bus.p_tick, bus.pixel_x, bus.pixel_y};
    endfunction

    // One clock: the model records what the frame latch sees, then samples at negedge.
    task automatic step();
        int unsigned p1;
        @(posedge clk);
        if (!reset) begin
            cyc   = 0;
            fm[0] = '0;
            fc[0] = '0;
        end else begin
            if ((cyc % CD) == CD - 1) begin
                p1 = cyc / CD + 1;
                if (p1 % FP == 0) begin
                    fm[(p1 / FP) % 16] = bus.mode;
                    fc[(p1 / FP) % 16] = bus.color;
                end
            end
            cyc++;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset(int n);
        reset = 1'b0;
        repeat (n) step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        vec_t got;
        bus.mode  = 2'($urandom);
        bus.color = 6'($urandom);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            got = observed();
            n_cmp++;
            if (got !== RST_VEC) begin
                n_fail++;
                $display("FAIL reset_vals i=%0d got=%h exp=%h", i, got, RST_VEC);
            end
        end
        reset = 1'b1;
        step();
        n_cmp++;
        if ({bus.p_tick, bus.video_on, bus.rgb, bus.pixel_x} !== {1'b1, 1'b1, 6'b0, 11'd0}) begin
            n_fail++;
            $display("FAIL first_tick got=p%b v%b rgb%h x%0d exp=p1 v1 rgb00 x0",
                     bus.p_tick, bus.video_on, bus.rgb, bus.pixel_x);
        end
        step();
        n_cmp++;
        if ({bus.p_tick, bus.pixel_x} !== {1'b0, 11'd1}) begin
            n_fail++;
            $display("FAIL second_cyc got=p%b x%0d exp=p0 x1", bus.p_tick, bus.pixel_x);
        end
    endtask

    task automatic test_solid();
        vec_t got, ex;
        int hs_run = 0, vs_run = 0, last_fall = -1;
        logic hs_prev = 1'b1, vs_prev = 1'b1;
        bus.mode  = 2'd0;
        bus.color = 6'($urandom);
        apply_reset(2);
        for (int i = 0; i < 2 * FC + 10 && n_fail < 64; i++) begin
            step();
            got = observed();
            ex  = model(cyc);
            n_cmp++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL solid cyc=%0d got=%h exp=%h", cyc, got, ex);
            end
            if (bus.hsync === POL) hs_run++;
            if (bus.hsync !== POL && hs_prev === POL) begin
                n_cmp++;
                if (hs_run != HS * CD) begin
                    n_fail++;
                    $display("FAIL hsync_width got=%0d exp=%0d", hs_run, HS * CD);
                end
                hs_run = 0;
            end
            if (bus.hsync === POL && hs_prev !== POL) begin
                if (last_fall >= 0) begin
                    n_cmp++;
                    if (int'(cyc) - last_fall != HT * CD) begin
                        n_fail++;
                        $display("FAIL hsync_period got=%0d exp=%0d", int'(cyc) - last_fall, HT * CD);
                    end
                end
                last_fall = int'(cyc);
            end
            if (bus.vsync === POL) vs_run++;
            if (bus.vsync !== POL && vs_prev === POL) begin
                n_cmp++;
                if (vs_run != VS * HT * CD) begin
                    n_fail++;
                    $display("FAIL vsync_width got=%0d exp=%0d", vs_run, VS * HT * CD);
                end
                vs_run = 0;
            end
            hs_prev = bus.hsync;
            vs_prev = bus.vsync;
        end
    endtask

    task automatic test_bars();
        vec_t got, ex;
        logic [2:0] kb;
        bus.mode  = 2'd1;
        bus.color = 6'($urandom);
        apply_reset(1);
        for (int i = 0; i < FC + HT * CD + 4 && n_fail < 64; i++) begin
            step();
            got = observed();
            ex  = model(cyc);
            n_cmp++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL bars cyc=%0d got=%h exp=%h", cyc, got, ex);
            end
            for (int k = 0; k < 9; k++) begin
                if (cyc == (FP + k * 4 + 1) * CD + 1) begin
                    kb = 3'(k);
                    n_cmp++;
                    if (bus.rgb !== {{CW{kb[2]}}, {CW{kb[1]}}, {CW{kb[0]}}}) begin
                        n_fail++;
                        $display("FAIL bar_%0d got=%h exp=%h", k, bus.rgb,
                                 {{CW{kb[2]}}, {CW{kb[1]}}, {CW{kb[0]}}});
                    end
                end
            end
        end
    endtask

    task automatic test_checker();
        vec_t got, ex;
        bus.mode  = 2'd2;
        bus.color = 6'b110000;
        apply_reset(1);
        for (int i = 0; i < FC + 6 * HT * CD && n_fail < 64; i++) begin
            step();
            got = observed();
            ex  = model(cyc);
            n_cmp++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL checker cyc=%0d got=%h exp=%h", cyc, got, ex);
            end
            if (cyc == FC + 1 || cyc == (FP + 4) * CD + 1 || cyc == (FP + 4 * HT + 4) * CD + 1) begin
                n_cmp++;
                if (bus.rgb !== ((cyc == (FP + 4) * CD + 1) ? 6'b001111 : 6'b110000)) begin
                    n_fail++;
                    $display("FAIL checker_px cyc=%0d got=%h exp=%h", cyc, bus.rgb,
                             (cyc == (FP + 4) * CD + 1) ? 6'b001111 : 6'b110000);
                end
            end
        end
    endtask

    task automatic test_scroll();
        vec_t got, ex;
        bus.mode  = 2'd3;
        bus.color = 6'($urandom);
        apply_reset(1);
        for (int i = 0; i < 8 * FC + 4 && n_fail < 64; i++) begin
            step();
            got = observed();
            ex  = model(cyc);
            n_cmp++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL scroll cyc=%0d got=%h exp=%h", cyc, got, ex);
            end
            for (int f = 1; f <= 8; f++) begin
                if (cyc == f * FC + 1) begin
                    n_cmp++;
                    if (bus.rgb !== scroll_exp[f-1] || bus.frame_start !== 1'b1) begin
                        n_fail++;
                        $display("FAIL scroll_f%0d got=rgb%h fs%b exp=rgb%h fs1", f,
                                 bus.rgb, bus.frame_start, scroll_exp[f-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_mid_frame_change();
        vec_t got, ex;
        logic [5:0] col_a;
        col_a     = 6'($urandom) | 6'b100000;
        bus.mode  = 2'd0;
        bus.color = col_a;
        apply_reset(1);
        for (int i = 0; i < 2 * FC + HT * CD && n_fail < 64; i++) begin
            if (cyc == (FP + 10 * HT) * CD) begin
                bus.mode  = 2'd1;
                bus.color = ~col_a;
            end
            step();
            got = observed();
            ex  = model(cyc);
            n_cmp++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL midchg cyc=%0d got=%h exp=%h", cyc, got, ex);
            end
            if (cyc == (FP + 12 * HT + 4) * CD + 1) begin
                n_cmp++;
                if (bus.rgb !== col_a) begin
                    n_fail++;
                    $display("FAIL midchg_hold got=%h exp=%h", bus.rgb, col_a);
                end
            end
            if (cyc == 2 * FC) begin
                n_cmp++;
                if (bus.frame_start !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midchg_early_fs got=%b exp=0", bus.frame_start);
                end
            end
            if (cyc == 2 * FC + 1) begin
                n_cmp++;
                if ({bus.frame_start, bus.rgb} !== {1'b1, 6'b000000}) begin
                    n_fail++;
                    $display("FAIL midchg_switch got=fs%b rgb%h exp=fs1 rgb00", bus.frame_start, bus.rgb);
                end
            end
            if (cyc == (2 * FP + 4) * CD + 1) begin
                n_cmp++;
                if (bus.rgb !== 6'b000011) begin
                    n_fail++;
                    $display("FAIL midchg_bar1 got=%h exp=03", bus.rgb);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        vec_t got, ex;
        int fs_count = 0;
        bus.mode  = 2'd2;
        bus.color = 6'($urandom);
        apply_reset(1);
        while (cyc < (FP + 23 * HT + 7) * CD && n_fail < 64) begin
            step();
            got = observed();
            ex  = model(cyc);
            n_cmp++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL prereset cyc=%0d got=%h exp=%h", cyc, got, ex);
            end
        end
        n_cmp++;
        if (bus.vsync !== POL) begin
            n_fail++;
            $display("FAIL prereset_vsync got=%b exp=%b", bus.vsync, POL);
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        got = observed();
        n_cmp++;
        if (got !== RST_VEC) begin
            n_fail++;
            $display("FAIL midreset_vals got=%h exp=%h", got, RST_VEC);
        end
        for (int i = 0; i < FC + 4 && n_fail < 64; i++) begin
            step();
            got = observed();
            ex  = model(cyc);
            n_cmp++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL postreset cyc=%0d got=%h exp=%h", cyc, got, ex);
            end
            if (bus.frame_start === 1'b1) begin
                fs_count++;
                n_cmp++;
                if (cyc != FC + 1) begin
                    n_fail++;
                    $display("FAIL postreset_fs_time got=%0d exp=%0d", cyc, FC + 1);
                end
            end
        end
        n_cmp++;
        if (fs_count != 1) begin
            n_fail++;
            $display("FAIL postreset_fs_count got=%0d exp=1", fs_count);
        end
    endtask

    task automatic test_back_to_back();
        vec_t got, ex;
        int unsigned next_chg;
        bus.mode  = 2'($urandom);
        bus.color = 6'($urandom);
        apply_reset(1);
        next_chg = $urandom_range(50, 400);
        for (int i = 0; i < 2 * FC + FC / 2 && n_fail < 64; i++) begin
            if (cyc >= next_chg) begin
                bus.mode  = 2'($urandom);
                bus.color = 6'($urandom);
                next_chg  = cyc + $urandom_range(50, 400);
            end
            step();
            got = observed();
            ex  = model(cyc);
            n_cmp++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, got, ex);
            end
        end
    endtask

    initial begin
        bus.mode  = '0;
        bus.color = '0;
        @(negedge clk);
        test_reset();
        test_solid();
        test_bars();
        test_checker();
        test_scroll();
        test_mid_frame_change();
        test_reset_mid_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
